// File: rtl/beef_alu_pipe.sv
// Pipelined BeeF cell ALU: INC/DEC/ADD/SUB/CLR/PASS with chaining, flags and a 2-entry output FIFO.
// Optional macro BEEF_ALU_SAT_EN: saturating INC/ADD/DEC/SUB, carry_o then flags saturation.
module beef_alu_pipe #(
  parameter int DATA_W = 8,
  parameter int STEP_W = DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              chain_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              carry_o,
  output logic              illegal_o
);

  localparam logic [2:0] OP_INC  = 3'd0;
  localparam logic [2:0] OP_DEC  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_CLR  = 3'd4;
  localparam logic [2:0] OP_PASS = 3'd5;

  // Returns {carry, result}; the top bit is the raw carry, or the saturation flag when clamping.
  function automatic logic [DATA_W:0] f_add(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef BEEF_ALU_SAT_EN
    if (s[DATA_W]) s = {1'b1, {DATA_W{1'b1}}};
`endif
    return s;
  endfunction

  // Borrow appears in the top bit of the DATA_W+1 wide difference.
  function automatic logic [DATA_W:0] f_sub(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W:0] d;
    d = {1'b0, a} - {1'b0, b};
`ifdef BEEF_ALU_SAT_EN
    if (d[DATA_W]) d = {1'b1, {DATA_W{1'b0}}};
`endif
    return d;
  endfunction

  logic [1:0]        r_count;
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [DATA_W-1:0] r_res0;
  logic [DATA_W-1:0] r_res1;
  logic [1:0]        r_zero;
  logic [1:0]        r_carry;
  logic [DATA_W-1:0] r_last;
  logic              r_illegal;

  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_step;
  logic [DATA_W:0]   w_calc;
  logic              w_zero;
  logic              w_illegal_op;
  logic              w_push;
  logic              w_pop;

  assign in_ready_o  = rst_n_i && (r_count < 2'd2);
  assign out_valid_o = (r_count != 2'd0);
  assign w_push      = in_valid_i && in_ready_o;
  assign w_pop       = out_valid_o && out_ready_i;

  assign w_step       = DATA_W'(step_i);
  assign w_a          = chain_i ? r_last : data_i;
  assign w_illegal_op = op_i[2] & op_i[1];
  assign w_zero       = ~|w_calc[DATA_W-1:0];

  always_comb begin
    w_calc = {1'b0, w_a};
    case (op_i)
      OP_INC:  w_calc = f_add(w_a, DATA_W'(1'b1));
      OP_DEC:  w_calc = f_sub(w_a, DATA_W'(1'b1));
      OP_ADD:  w_calc = f_add(w_a, w_step);
      OP_SUB:  w_calc = f_sub(w_a, w_step);
      OP_CLR:  w_calc = '0;
      OP_PASS: w_calc = {1'b0, w_a};
      default: w_calc = {1'b0, w_a};
    endcase
  end

  // Accept stage: write computed entry into the FIFO and update chain/illegal state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_res0    <= '0;
      r_res1    <= '0;
      r_zero    <= '0;
      r_carry   <= '0;
      r_wr_ptr  <= 1'b0;
      r_last    <= '0;
      r_illegal <= 1'b0;
    end else if (w_push) begin
      if (r_wr_ptr) r_res1 <= w_calc[DATA_W-1:0];
      else          r_res0 <= w_calc[DATA_W-1:0];
      r_zero[r_wr_ptr]  <= w_zero;
      r_carry[r_wr_ptr] <= w_calc[DATA_W];
      r_wr_ptr          <= ~r_wr_ptr;
      r_last            <= w_calc[DATA_W-1:0];
      if (w_illegal_op) r_illegal <= 1'b1;
    end
  end

  // Output stage: head pointer and occupancy
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign result_o  = r_rd_ptr ? r_res1 : r_res0;
  assign zero_o    = r_zero[r_rd_ptr];
  assign carry_o   = r_carry[r_rd_ptr];
  assign illegal_o = r_illegal;

endmodule

// File: tb/tb_beef_alu_pipe.sv
// Scoreboard bench for beef_alu_pipe (DATA_W=8); honours BEEF_ALU_SAT_EN when defined.
module tb_beef_alu_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] data;
  logic [W-1:0] step;
  logic         chain;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         illegal;

  beef_alu_pipe #(.DATA_W(W), .STEP_W(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .data_i(data), .step_i(step), .chain_i(chain),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
    .zero_o(zero), .carry_o(carry), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         c;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   model_last = 0;
  bit   rand_ordy = 0;

  function automatic exp_t model(input int o, input int a, input int s);
    int   v;
    exp_t e;
    case (o)
      0: v = a + 1;
      1: v = a - 1;
      2: v = a + s;
      3: v = a - s;
      4: v = 0;
      default: v = a;
    endcase
`ifdef BEEF_ALU_SAT_EN
    if (v > (1 << W) - 1) begin e.res = W'((1 << W) - 1); e.c = 1'b1; end
    else if (v < 0)       begin e.res = '0;                e.c = 1'b1; end
    else                  begin e.res = W'(v);             e.c = 1'b0; end
`else
    e.c   = (v > (1 << W) - 1) || (v < 0);
    e.res = W'(v & ((1 << W) - 1));
`endif
    e.z = (e.res == '0);
    return e;
  endfunction

  // Scoreboard monitor: a pop happens at the next rising edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL pop_unexpected: got res=%h with empty scoreboard", result);
      end else begin
        e = sb.pop_front();
        if (result !== e.res || zero !== e.z || carry !== e.c)
          $display("FAIL pop_entry: got res=%h z=%b c=%b, expected res=%h z=%b c=%b",
                   result, zero, carry, e.res, e.z, e.c);
        else n_pass++;
      end
    end
  end

  task automatic send(input int o, input int d, input int s, input bit ch);
    int   a;
    exp_t e;
    bit   done = 0;
    op = 3'(o); data = W'(d); step = W'(s); chain = ch; in_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      if (rand_ordy) out_ready = 1'($urandom_range(0, 1));
      if (in_ready) begin
        a = ch ? model_last : d;
        e = model(o, a, s);
        sb.push_back(e);
        model_last = int'(e.res);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready);
    end
  endtask

  task automatic drain();
    rand_ordy = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (sb.size() != 0 || out_valid); i++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (sb.size() != 0 || out_valid !== 1'b0)
      $display("FAIL drain: %0d entries left, out_valid=%b, expected 0 and 0", sb.size(), out_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; op = 3'd0; data = 8'h11; step = '0; chain = 1'b0;
    out_ready = 1'b1;
    #12;
    n_checks++;
    if ({in_ready, out_valid, result, zero, carry, illegal} !== '0)
      $display("FAIL reset_outputs: rdy=%b vld=%b res=%h z=%b c=%b ill=%b, expected all 0",
               in_ready, out_valid, result, zero, carry, illegal);
    else n_pass++;
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: rdy=%b vld=%b, expected 1 and 0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_wrap();
    out_ready = 1'b0;
    send(0, 8'hFF, 0, 0);
    n_checks++;
`ifdef BEEF_ALU_SAT_EN
    if (result !== 8'hFF || zero !== 1'b0 || carry !== 1'b1)
      $display("FAIL inc_ff: res=%h z=%b c=%b, expected res=ff z=0 c=1", result, zero, carry);
`else
    if (result !== 8'h00 || zero !== 1'b1 || carry !== 1'b1)
      $display("FAIL inc_ff: res=%h z=%b c=%b, expected res=00 z=1 c=1", result, zero, carry);
`endif
    else n_pass++;
    drain();
    out_ready = 1'b0;
    send(3, 8'h05, 8'h07, 0);
    n_checks++;
`ifdef BEEF_ALU_SAT_EN
    if (result !== 8'h00 || zero !== 1'b1 || carry !== 1'b1)
      $display("FAIL sub_borrow: res=%h z=%b c=%b, expected res=00 z=1 c=1", result, zero, carry);
`else
    if (result !== 8'hFE || zero !== 1'b0 || carry !== 1'b1)
      $display("FAIL sub_borrow: res=%h z=%b c=%b, expected res=fe z=0 c=1", result, zero, carry);
`endif
    else n_pass++;
    drain();
  endtask

  task automatic test_chain();
    out_ready = 1'b1;
    send(2, 8'h10, 3, 0);
    send(0, 8'hAA, 0, 1);
    send(1, 8'hAA, 0, 1);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== 8'h13)
      $display("FAIL chain_steady: vld=%b rdy=%b res=%h, expected 1 1 13", out_valid, in_ready, result);
    else n_pass++;
    drain();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] head;
    out_ready = 1'b0;
    send(2, 8'h40, 1, 0);
    send(5, 8'h77, 0, 0);
    op = 3'd0; data = 8'h01; chain = 1'b0; in_valid = 1'b1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 8'h41)
      $display("FAIL bp_full: rdy=%b vld=%b res=%h, expected 0 1 41", in_ready, out_valid, result);
    else n_pass++;
    head = result;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if (in_ready !== 1'b0 || result !== head)
      $display("FAIL bp_hold: rdy=%b res=%h, expected 0 %h", in_ready, result, head);
    else n_pass++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || result !== 8'h77)
      $display("FAIL bp_pop1: rdy=%b vld=%b res=%h, expected 1 1 77", in_ready, out_valid, result);
    else n_pass++;
    drain();
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    send(6, 8'h2A, 0, 0);
    n_checks++;
    if (result !== 8'h2A || carry !== 1'b0 || illegal !== 1'b1)
      $display("FAIL illegal_op: res=%h c=%b ill=%b, expected 2a 0 1", result, carry, illegal);
    else n_pass++;
    drain();
    send(0, 8'h05, 0, 0);
    send(4, 8'h33, 0, 0);
    drain();
    n_checks++;
    if (illegal !== 1'b1)
      $display("FAIL illegal_sticky: ill=%b, expected 1", illegal);
    else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(2, 8'h20, 8'h20, 0);
    send(5, 8'h99, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 8'h00 || illegal !== 1'b0)
      $display("FAIL flush: vld=%b rdy=%b res=%h ill=%b, expected 0 0 00 0",
               out_valid, in_ready, result, illegal);
    else n_pass++;
    sb.delete();
    model_last = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(0, 8'h55, 0, 1);
    n_checks++;
    if (result !== 8'h01 || carry !== 1'b0)
      $display("FAIL last_reset: res=%h c=%b, expected 01 0", result, carry);
    else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    rand_ordy = 1;
    for (int i = 0; i < 40; i++)
      send($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
           1'($urandom_range(0, 1)));
    drain();
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_chain();
    test_backpressure();
    test_illegal();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
